// File: rtl/midi_pkg.sv
// Shared MIDI definitions: system real-time byte values, default bit rate,
// receiver state encoding and the 3-sample majority helper.
package midi_pkg;

    localparam logic [7:0] TIME_CLOCK   = 8'hF8;
    localparam logic [7:0] TIME_START   = 8'hFA;
    localparam logic [7:0] TIME_CONT    = 8'hFB;
    localparam logic [7:0] TIME_STOP    = 8'hFC;
    localparam logic [7:0] ACTIVE_SENSE = 8'hFE;

    localparam int DEFAULT_BAUD = 31_250;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/midi_baud_tick.sv
// Oversampling prescaler: one-cycle tick every DIV clocks, restartable by a
// synchronous clear so the tick phase can be aligned to a start edge.
module midi_baud_tick #(
    parameter int DIV = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("midi_baud_tick: DIV must be at least 2");
    end

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI IN receiver: 8N1, 16x oversampling, 2-flop synchronizer, majority vote.
// Optional build macro MIDI_RX_ACTIVE_SENSE_FILTER_EN drops Active Sensing (8'hFE).
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = DEFAULT_BAUD,
    parameter int OVS    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_in,
    output logic [7:0] midi_word,
    output logic       midi_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int DIV = (CLK_HZ + BAUD * OVS / 2) / (BAUD * OVS);

    if (OVS != 16) begin : g_ovs_check
        $error("midi_uart_rx: only OVS = 16 is supported");
    end

    logic       sync1_reg, sync2_reg;
    logic       rx_s;
    logic       tick;
    logic       clr;

    rx_state_t  state_reg, state_next;
    logic [3:0] tc_reg, tc_next;
    logic [2:0] bit_idx_reg, bit_idx_next;
    logic [7:0] shreg_reg, shreg_next;
    logic [1:0] samp_reg, samp_next;
    logic [7:0] word_reg, word_next;
    logic       valid_reg, valid_next;
    logic       ferr_reg, ferr_next;
    logic       bk_ok_reg, bk_ok_next;

    logic [3:0] tc_inc;
    logic       maj;
    logic       in_frame;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= midi_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign rx_s = sync2_reg;

    midi_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    // tc holds the index of the latest tick; the start detection itself is tick 0.
    assign tc_inc   = tc_reg + 4'd1;
    assign maj      = majority3(samp_reg[1], samp_reg[0], rx_s);
    assign in_frame = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);

    always_comb begin
        state_next   = state_reg;
        tc_next      = tc_reg;
        bit_idx_next = bit_idx_reg;
        shreg_next   = shreg_reg;
        samp_next    = samp_reg;
        word_next    = word_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        bk_ok_next   = bk_ok_reg;
        clr          = 1'b0;

        if (in_frame && tick) begin
            tc_next = tc_inc;
            if (tc_inc == 4'd7) samp_next[1] = rx_s;
            if (tc_inc == 4'd8) samp_next[0] = rx_s;
        end

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next   = START;
                    tc_next      = 4'd0;
                    bit_idx_next = 3'd0;
                    clr          = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (tc_inc == 4'd9 && maj) begin
                        state_next = IDLE;
                    end else if (tc_inc == 4'd0) begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tc_inc == 4'd9) begin
                        shreg_next = {maj, shreg_reg[7:1]};
                    end
                    if (tc_inc == 4'd0) begin
                        if (bit_idx_reg == 3'd7) begin
                            state_next = STOP;
                        end else begin
                            bit_idx_next = bit_idx_reg + 3'd1;
                        end
                    end
                end
            end
            STOP: begin
                // Leave mid-stop-bit so the next start edge is caught early.
                if (tick && tc_inc == 4'd9) begin
                    if (maj) begin
                        state_next = IDLE;
`ifdef MIDI_RX_ACTIVE_SENSE_FILTER_EN
                        if (shreg_reg != ACTIVE_SENSE) begin
                            word_next  = shreg_reg;
                            valid_next = 1'b1;
                        end
`else
                        word_next  = shreg_reg;
                        valid_next = 1'b1;
`endif
                    end else begin
                        ferr_next  = 1'b1;
                        bk_ok_next = 1'b0;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Line must stay high across a whole tick interval before rearming.
                if (!rx_s) begin
                    bk_ok_next = 1'b0;
                end else if (tick) begin
                    if (bk_ok_reg) begin
                        state_next = IDLE;
                    end else begin
                        bk_ok_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            tc_reg      <= 4'd0;
            bit_idx_reg <= 3'd0;
            shreg_reg   <= 8'h00;
            samp_reg    <= 2'b00;
            word_reg    <= 8'h00;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            bk_ok_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tc_reg      <= tc_next;
            bit_idx_reg <= bit_idx_next;
            shreg_reg   <= shreg_next;
            samp_reg    <= samp_next;
            word_reg    <= word_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
            bk_ok_reg   <= bk_ok_next;
        end
    end

    assign midi_word  = word_reg;
    assign midi_valid = valid_reg;
    assign frame_err  = ferr_reg;
    assign rx_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Scoreboard bench for midi_uart_rx at default parameters (24 clocks per tick,
// 384 clocks per bit); expectations follow MIDI_RX_ACTIVE_SENSE_FILTER_EN.
module tb_midi_uart_rx;

    localparam int CPB      = 384;
    localparam int CPB_FAST = 373;
    localparam int LATENCY  = 3674;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       midi_in = 1'b1;
    logic [7:0] midi_word;
    logic       midi_valid;
    logic       frame_err;
    logic       rx_busy;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        longint     fall_cyc;
        logic       chk_lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    midi_uart_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .midi_in   (midi_in),
        .midi_word (midi_word),
        .midi_valid(midi_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at cyc=%0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic push(input logic is_err, input logic [7:0] data, input logic chk_lat);
        exp_t x;
        x.is_err   = is_err;
        x.data     = data;
        x.fall_cyc = cyc + 1;
        x.chk_lat  = chk_lat;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        midi_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-clock line driver: start, 8 data LSB first, optional low stop period,
    // then one high stop bit. Optional single-clock glitch and 1-cycle reset.
    task automatic send_frame(input logic [7:0] b, input int cpb, input int stop_low,
                              input int glitch_t, input int rst_t);
        int   total;
        int   idx;
        logic v;
        total = 9 * cpb + stop_low * cpb + cpb;
        for (int t = 0; t < total; t++) begin
            idx = t / cpb;
            if (idx == 0)                        v = 1'b0;
            else if (idx <= 8)                   v = b[idx-1];
            else if (t < 9 * cpb + stop_low * cpb) v = 1'b0;
            else                                 v = 1'b1;
            if (t == glitch_t) v = ~v;
            midi_in = v;
            rst_n   = (t == rst_t) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expectation per output pulse.
    always @(negedge clk) begin
        if (midi_valid || frame_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {midi_valid, frame_err}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("exclusive", midi_valid & frame_err, 0);
                chk("event_kind", frame_err, e.is_err);
                if (!e.is_err) chk("midi_word", midi_word, e.data);
                if (e.chk_lat) chk("latency", cyc - e.fall_cyc, LATENCY);
                if (frame_err)
                    $display("RX frame_err            cyc=%0d", cyc);
                else
                    $display("RX byte=%02h expect=%02h cyc=%0d", midi_word, e.data, cyc);
            end
        end
    end

    initial begin
        #(10 * 200_000);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        midi_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_word", midi_word, 8'h00);
        chk("reset_valid", midi_valid, 0);
        chk("reset_ferr", frame_err, 0);
        chk("reset_busy", rx_busy, 0);
        rst_n = 1'b1;
        idle(20);

        // Clean byte at exact baud with latency check.
        push(1'b0, 8'h92, 1'b1);
        send_frame(8'h92, CPB, 0, -1, -1);
        idle(2 * CPB);

        // Back-to-back at +3% baud.
        push(1'b0, 8'h92, 1'b0);
        send_frame(8'h92, CPB_FAST, 0, -1, -1);
        push(1'b0, 8'h3C, 1'b0);
        send_frame(8'h3C, CPB_FAST, 0, -1, -1);
        push(1'b0, 8'h64, 1'b0);
        send_frame(8'h64, CPB_FAST, 0, -1, -1);
        idle(2 * CPB);

        // 5-clock low glitch: busy briefly, back to idle within a bit time.
        midi_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("glitch_busy", rx_busy, 1);
        idle(CPB - 5);
        chk("glitch_idle", rx_busy, 0);
        idle(CPB);

        // Inverted clock at tc=8 of data bit 3 (edge offset 4*384+192).
        push(1'b0, 8'h92, 1'b1);
        send_frame(8'h92, CPB, 0, 4 * CPB + 192, -1);
        idle(2 * CPB);

        // Stop bit low for 3 bit times: one frame_err, word held.
        push(1'b1, 8'h00, 1'b0);
        send_frame(8'h55, CPB, 3, -1, -1);
        idle(2 * CPB);
        chk("word_hold", midi_word, 8'h92);
        chk("break_exit", rx_busy, 0);

        push(1'b0, 8'hF8, 1'b1);
        send_frame(8'hF8, CPB, 0, -1, -1);
        idle(2 * CPB);

        // Active Sensing followed by timing clock.
`ifndef MIDI_RX_ACTIVE_SENSE_FILTER_EN
        push(1'b0, 8'hFE, 1'b1);
`endif
        send_frame(8'hFE, CPB, 0, -1, -1);
`ifdef MIDI_RX_ACTIVE_SENSE_FILTER_EN
        chk("filter_word_hold", midi_word, 8'hF8);
`endif
        push(1'b0, 8'hF8, 1'b1);
        send_frame(8'hF8, CPB, 0, -1, -1);
        idle(2 * CPB);

        // Reset pulse mid data bit 4; remaining bits of 8'hF3 keep the line high.
        send_frame(8'hF3, CPB, 0, -1, 5 * CPB + 192);
        chk("rst_mid_word", midi_word, 8'h00);
        chk("rst_mid_busy", rx_busy, 0);
        idle(2 * CPB);

        push(1'b0, 8'h80, 1'b1);
        send_frame(8'h80, CPB, 0, -1, -1);

        for (int i = 0; i < 5000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
